// File: rtl/wupr_refresh_issuer_if.sv
// Bundle between the refresh issuer, the WUPR tracker and the DRAM command
// scheduler. The issuer side is the master; the environment is the slave.
interface wupr_refresh_issuer_if #(
  parameter int ROW_WIDTH    = 16,
  parameter int MAX_POSTPONE = 8,
  parameter int CNT_WIDTH    = 16
);
  localparam int PEND_W = $clog2(MAX_POSTPONE + 1);

  logic                 to_refresh;
  logic [ROW_WIDTH-1:0] Ra;
  logic                 dref;
  logic                 rt_write_busy;
  logic                 ref_req;
  logic [ROW_WIDTH-1:0] ref_row;
  logic                 ref_ack;
  logic [PEND_W-1:0]    pending;
  logic                 urgent;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] issued_cnt;
  logic [CNT_WIDTH-1:0] skipped_cnt;

  modport master (
    output to_refresh, Ra, ref_req, ref_row,
    output pending, urgent, overflow, issued_cnt, skipped_cnt,
    input  dref, rt_write_busy, ref_ack
  );

  modport slave (
    input  to_refresh, Ra, ref_req, ref_row,
    input  pending, urgent, overflow, issued_cnt, skipped_cnt,
    output dref, rt_write_busy, ref_ack
  );
endinterface

// File: rtl/wupr_refresh_issuer.sv
// Refresh-side initiator for the WUPR partial-refresh tracker.
// Times tREFI, keeps the postpone budget, queries WUPR for each due slot and
// either issues a real refresh to the scheduler or retires the slot as a skip.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | waiting for a pending slot and a free Ra path (or urgency)
// QUERY       | to_refresh pulse, Ra = current row
// WAIT_DREF   | Ra held, WUPR verdict sampled; skip retires here
// ISSUE       | ref_req held with ref_row until the scheduler acks
module wupr_refresh_issuer #(
  parameter int ROW_WIDTH      = 16,
  parameter int REFRESH_PERIOD = 3900,
  parameter int MAX_POSTPONE   = 8,
  parameter int CNT_WIDTH      = 16
) (
  input logic clk,
  input logic rst_n,
  wupr_refresh_issuer_if.master bus
);

  localparam int IVL_W  = $clog2(REFRESH_PERIOD);
  localparam int PEND_W = $clog2(MAX_POSTPONE + 1);

  localparam logic [IVL_W-1:0]     IVL_LAST = IVL_W'(REFRESH_PERIOD - 1);
  localparam logic [PEND_W-1:0]    PEND_MAX = PEND_W'(MAX_POSTPONE);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_QUERY     = 2'd1;
  localparam logic [1:0] S_WAIT_DREF = 2'd2;
  localparam logic [1:0] S_ISSUE     = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IVL_W-1:0]     ivl_q, ivl_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [ROW_WIDTH-1:0] ref_row_q, ref_row_d;
  logic [PEND_W-1:0]    pending_q, pending_d;
  logic                 urgent_q;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] skipped_q, skipped_d;

  logic tick;
  logic retire_skip;
  logic retire_issue;
  logic retire;

  // Interval timer and retire events for this cycle.
  always_comb begin
    tick         = (ivl_q == IVL_LAST);
    ivl_d        = tick ? '0 : ivl_q + 1'b1;
    retire_skip  = (state_q == S_WAIT_DREF) && bus.dref;
    retire_issue = (state_q == S_ISSUE) && bus.ref_ack;
    retire       = retire_skip || retire_issue;
  end

  // Postpone budget: a retire frees its slot before a same-edge tick claims one.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (tick && !retire) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + 1'b1;
    end else if (retire && !tick) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // Row walk and saturating statistics.
  always_comb begin
    row_d     = retire ? row_q + 1'b1 : row_q;
    issued_d  = (retire_issue && (issued_q != CNT_MAX)) ? issued_q + 1'b1 : issued_q;
    skipped_d = (retire_skip && (skipped_q != CNT_MAX)) ? skipped_q + 1'b1 : skipped_q;
  end

  // Sequencer next state; urgency lets a query steal the Ra path from writes.
  always_comb begin
    state_d   = state_q;
    ref_row_d = ref_row_q;
    case (state_q)
      S_IDLE: begin
        if ((pending_q != '0) && (!bus.rt_write_busy || urgent_q)) state_d = S_QUERY;
      end
      S_QUERY: state_d = S_WAIT_DREF;
      S_WAIT_DREF: begin
        if (bus.dref) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_ISSUE;
          ref_row_d = row_q;
        end
      end
      S_ISSUE: begin
        if (bus.ref_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ivl_q      <= '0;
      row_q      <= '0;
      ref_row_q  <= '0;
      pending_q  <= '0;
      urgent_q   <= 1'b0;
      overflow_q <= 1'b0;
      issued_q   <= '0;
      skipped_q  <= '0;
    end else begin
      state_q    <= state_d;
      ivl_q      <= ivl_d;
      row_q      <= row_d;
      ref_row_q  <= ref_row_d;
      pending_q  <= pending_d;
      urgent_q   <= (pending_d == PEND_MAX);
      overflow_q <= overflow_d;
      issued_q   <= issued_d;
      skipped_q  <= skipped_d;
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free.
  assign bus.to_refresh  = (state_q == S_QUERY);
  assign bus.Ra          = ((state_q == S_QUERY) || (state_q == S_WAIT_DREF)) ? row_q : '0;
  assign bus.ref_req     = (state_q == S_ISSUE);
  assign bus.ref_row     = ref_row_q;
  assign bus.pending     = pending_q;
  assign bus.urgent      = urgent_q;
  assign bus.overflow    = overflow_q;
  assign bus.issued_cnt  = issued_q;
  assign bus.skipped_cnt = skipped_q;

endmodule

// File: doc/wupr_refresh_issuer.md
# wupr_refresh_issuer

Refresh-side initiator for the WUPR write-update partial-refresh tracker. It times the refresh interval and walks the row address. For each due refresh it queries WUPR (`to_refresh`/`Ra`), samples the returned `dref` verdict, and then takes one of two actions: it issues a real refresh to the DRAM command scheduler through a req/ack handshake, or it retires the slot as a dummy (skipped) refresh. It sits between WUPR and the command scheduler and holds the pending-refresh (postpone) budget.

## Interface
Parameters:
- `ROW_WIDTH`, 16, width of the row address `Ra` / `ref_row`.
- `REFRESH_PERIOD`, 3900, cycles between refresh ticks (tREFI); minimum 2.
- `MAX_POSTPONE`, 8, maximum outstanding refresh slots; minimum 1.
- `CNT_WIDTH`, 16, width of the issued/skipped statistics counters.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `to_refresh`  out  1  query strobe to WUPR; one-cycle pulse.
- `Ra`  out  ROW_WIDTH  row queried; valid in QUERY and WAIT_DREF.
- `dref`  in  1  WUPR verdict, registered by WUPR; 1 = dummy (skip), 0 = real refresh needed.
- `rt_write_busy`  in  1  a WUPR write (`Rt_write`) is using the shared `Ra` path this cycle.
- `ref_req`  out  1  refresh command request to the scheduler.
- `ref_row`  out  ROW_WIDTH  row for `ref_req`; stable while `ref_req` is high.
- `ref_ack`  in  1  scheduler accepts the refresh.
- `pending`  out  $clog2(MAX_POSTPONE+1)  outstanding refresh slots.
- `urgent`  out  1  `pending == MAX_POSTPONE`.
- `overflow`  out  1  sticky: a tick arrived while `pending == MAX_POSTPONE`.
- `issued_cnt`  out  CNT_WIDTH  real refreshes completed; saturating.
- `skipped_cnt`  out  CNT_WIDTH  dummy refreshes retired; saturating.

## Operation
- Interval counter `ivl` runs 0..REFRESH_PERIOD-1 and wraps. `tick` = (`ivl` == REFRESH_PERIOD-1).
- `tick` increments `pending`, saturating at MAX_POSTPONE. A tick while saturated sets `overflow`.
- A row pointer `row` starts at 0. It advances by 1 on each retired slot (real or dummy), wrapping from 2^ROW_WIDTH-1 to 0.
- FSM states:
  - IDLE: go to QUERY when `pending` > 0 and (`rt_write_busy` == 0 or `urgent`).
  - QUERY: `to_refresh` = 1, `Ra` = `row`. Always go to WAIT_DREF.
  - WAIT_DREF: `Ra` = `row`; sample `dref`. If `dref` = 1, the slot is retired as a skip: `skipped_cnt`++ and go to IDLE. If `dref` = 0, latch `ref_row` = `row` and go to ISSUE.
  - ISSUE: `ref_req` = 1. On `ref_ack` = 1, the slot is retired as issued: `issued_cnt`++ and go to IDLE.
- Retire: `pending` decrements and `row` advances on the same edge.
- Tick and retire on the same edge: `pending` is unchanged (net 0). No overflow is flagged, because the retire frees the slot first.
- `Ra` = 0 outside QUERY/WAIT_DREF. `to_refresh` is never high outside QUERY.
- `urgent` overrides the write hold-off. The external mux gives the refresh query priority in that case.

## Timing
- Reset values (applied on the first edge with `rst_n` = 0): state IDLE; `ivl`, `row`, `pending`, `ref_row`, `Ra` = 0; `to_refresh`, `ref_req`, `urgent`, `overflow` = 0; both counters = 0.
- Reset mid-handshake drops `ref_req` on the next edge without an ack. The slot is lost and is not counted.
- First tick: the REFRESH_PERIOD-th cycle after `rst_n` rises. `pending` = 1 on the following cycle.
- Skip path latency: `pending` becomes 1 → QUERY next cycle → WAIT_DREF → retired. 3 cycles, back in IDLE.
- Issue path: `ref_req` rises 3 cycles after `pending` becomes 1. It holds, with `ref_row` stable, until the cycle `ref_ack` = 1, and is low on the next cycle.
- `ref_ack` while `ref_req` = 0 is ignored.
- `dref` is sampled only in WAIT_DREF, i.e. exactly 1 cycle after `to_refresh`.
- Minimum spacing between `to_refresh` pulses is 3 cycles.
- `urgent` and `pending` are registered outputs.

## Test plan
- Bench uses REFRESH_PERIOD = 16, MAX_POSTPONE = 4, ROW_WIDTH = 16.
- Tick, `dref` = 0, `ref_ack` 2 cycles after `ref_req` → `to_refresh` pulse with `Ra` = 0, `ref_req` with `ref_row` = 0 held 2 cycles, then `issued_cnt` = 1, `pending` = 0, next query uses `Ra` = 1.
- Tick with `dref` = 1 → no `ref_req`, `skipped_cnt` = 1, `row` = 1, back in IDLE 3 cycles after `pending` became 1.
- `ref_ack` held low for 5 ticks → `pending` reaches 4 with `urgent` = 1, fifth tick sets `overflow` = 1 while `pending` stays 4. Then ack → `pending` = 3, `overflow` stays 1.
- `rt_write_busy` = 1 continuously with `pending` = 1 → no query. Raise `pending` to 4 → query proceeds despite busy.
- Preload `row` = 0xFFFF, retire one slot → next query `Ra` = 0x0000. Retire coinciding with tick → `pending` unchanged.
- `rst_n` = 0 for one cycle while in ISSUE → next cycle `ref_req` = 0, all outputs at reset values, next tick 16 cycles after release.
